// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD pipeline front end.
package simd_pkg;

  localparam int INSTR_W = 25;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 25'h1800000;

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    RUN,
    DRAIN,
    DONE
  } ifu_state_t;

endpackage

// File: rtl/ifu_prog_mem.sv
// Program memory for the fetch unit: one synchronous write port and an
// asynchronous read port addressed by the program counter.
module ifu_prog_mem #(
  parameter int DEPTH   = 64,
  parameter int INSTR_W = 25,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; a program is always loaded before use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Loadable-program instruction fetch stage: load, run with stall, drain NOPs, done.
// Define IFU_PERF_CNT_EN to add saturating issued_cnt / stall_cnt outputs.
module instr_fetch_unit
  import simd_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int INSTR_W      = 25,
  parameter int DRAIN_CYCLES = 4,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               overflow
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]        issued_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int CW = AW + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  ifu_state_t         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic               full;
  logic               load_fire;
  logic [AW-1:0]      mem_waddr;
  logic [INSTR_W-1:0] mem_rdata;

  assign full = (count_q == CW'(DEPTH));

  // LOADED and DONE accept a word too: it restarts the load at entry 0.
  assign load_ready = ((state_q == IDLE) && !full) || (state_q == LOADED) || (state_q == DONE);
  assign load_fire  = load_valid && load_ready;
  assign mem_waddr  = (state_q == IDLE) ? count_q[AW-1:0] : '0;

  ifu_prog_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (load_fire),
    .waddr_i (mem_waddr),
    .wdata_i (load_instr),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (load_fire) begin
          count_d = count_q + CW'(1);
          if (load_last) begin
            state_d = LOADED;
          end
        end else if (full) begin
          if (load_valid) begin
            ovf_d = 1'b1;
          end
          if (load_last) begin
            state_d = LOADED;
          end
        end
      end

      LOADED: begin
        if (load_valid) begin
          count_d = CW'(1);
          state_d = load_last ? LOADED : IDLE;
        end else if (start && (count_q != '0)) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end

      RUN: begin
        if (!stall) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          pc_d    = pc_q + AW'(1);
          if ({1'b0, pc_q} == (count_q - CW'(1))) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end
        end
      end

      DRAIN: begin
        if (!stall) begin
          instr_d = NOP;
          valid_d = 1'b0;
          if (drain_q == '0) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end

      DONE: begin
        if (load_valid) begin
          count_d = CW'(1);
          state_d = load_last ? LOADED : IDLE;
        end else if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= '0;
      drain_q <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

`ifdef IFU_PERF_CNT_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if ((state_q != RUN) && (state_d == RUN)) begin
      issued_d = '0;
      stall_d  = '0;
    end else begin
      if ((state_q == RUN) && !stall && (issued_q != 16'hFFFF)) begin
        issued_d = issued_q + 16'd1;
      end
      if (busy && stall && (stall_q != 16'hFFFF)) begin
        stall_d = stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, hand-written
// overflow/reset sequences, and randomized programs against a trace model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 64;
  localparam int DRN   = 4;
  localparam logic [24:0] NOPW = 25'h1800000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [24:0] load_instr = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [24:0] instr_out;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] issued_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [24:0] prog [DEPTH];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_instr  (load_instr),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .start       (start),
    .stall       (stall),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
`ifdef IFU_PERF_CNT_EN
    ,
    .issued_cnt  (issued_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        lv;
    logic [24:0] d;
    logic        last;
    logic        st;
    logic        sl;
    logic        ready;
    logic [24:0] out;
    logic        vld;
    logic [5:0]  pc;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(input logic lv, input logic [24:0] d, input logic last,
                              input logic st, input logic sl, input logic ready,
                              input logic [24:0] out, input logic vld, input logic [5:0] p,
                              input logic bsy, input logic dn);
    vec_t v;
    v.lv = lv; v.d = d; v.last = last; v.st = st; v.sl = sl;
    v.ready = ready; v.out = out; v.vld = vld; v.pc = p; v.busy = bsy; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_instr = '0; load_last = 1'b0; start = 1'b0; stall = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected outputs after k unstalled edges since the start edge.
  task automatic expect_run(input string tag, input int n, input int k);
    logic [24:0] e_out;
    logic        e_vld;
    logic [5:0]  e_pc;
    logic        e_busy;
    logic        e_done;
    if (k == 0) begin
      e_out = NOPW; e_vld = 1'b0; e_pc = '0; e_busy = 1'b1; e_done = 1'b0;
    end else if (k <= n) begin
      e_out = prog[k-1]; e_vld = 1'b1; e_pc = 6'(k % DEPTH); e_busy = 1'b1; e_done = 1'b0;
    end else begin
      e_out = NOPW; e_vld = 1'b0; e_pc = 6'(n % DEPTH);
      e_busy = (k < n + DRN); e_done = (k == n + DRN);
    end
    chk({tag, ".out"},   32'(instr_out),   32'(e_out));
    chk({tag, ".vld"},   32'(instr_valid), 32'(e_vld));
    chk({tag, ".pc"},    32'(pc),          32'(e_pc));
    chk({tag, ".busy"},  32'(busy),        32'(e_busy));
    chk({tag, ".done"},  32'(done),        32'(e_done));
    chk({tag, ".ready"}, 32'(load_ready),  32'(!e_busy));
  endtask

  task automatic load_prog(input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) prog[i] = 25'($urandom);
    while (acc < n) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_instr = prog[acc];
      load_last  = (acc == n - 1);
      stall      = $urandom_range(0, 1);
      tick();
      chk($sformatf("load%0d.busy", acc), 32'(busy), 32'd0);
      chk($sformatf("load%0d.ready", acc), 32'(load_ready), 32'd1);
      if (load_valid) acc++;
    end
    idle_inputs();
  endtask

  task automatic run_prog(input int n);
    int  k = 0;
    logic st;
    start = 1'b1;
    stall = $urandom_range(0, 1);
    tick();
    start = 1'b0;
    expect_run("run.k0", n, 0);
    for (int c = 0; c < 4000 && k < n + DRN; c++) begin
      st    = ($urandom_range(0, 2) == 0);
      stall = st;
      start = ($urandom_range(0, 7) == 0);
      tick();
      if (!st) k++;
      expect_run($sformatf("run.k%0d", k), n, k);
    end
    chk("run.finished", 32'(k), 32'(n + DRN));
    idle_inputs();
  endtask

  initial begin
    // Rows: inputs applied before an edge, outputs expected after it.
    tbl[0]  = mk(1, 25'd1, 0, 0, 0, 1, NOPW, 0, 0, 0, 0);
    tbl[1]  = mk(1, 25'd2, 0, 0, 0, 1, NOPW, 0, 0, 0, 0);
    tbl[2]  = mk(1, 25'd3, 1, 0, 0, 1, NOPW, 0, 0, 0, 0);
    tbl[3]  = mk(0, 25'd0, 0, 1, 1, 0, NOPW, 0, 0, 1, 0);
    tbl[4]  = mk(0, 25'd0, 0, 0, 0, 0, 25'd1, 1, 1, 1, 0);
    tbl[5]  = mk(0, 25'd0, 0, 0, 0, 0, 25'd2, 1, 2, 1, 0);
    tbl[6]  = mk(0, 25'd0, 0, 0, 1, 0, 25'd2, 1, 2, 1, 0);
    tbl[7]  = mk(0, 25'd0, 0, 1, 1, 0, 25'd2, 1, 2, 1, 0);
    tbl[8]  = mk(0, 25'd0, 0, 0, 0, 0, 25'd3, 1, 3, 1, 0);
    tbl[9]  = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 3, 1, 0);
    tbl[10] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 3, 1, 0);
    tbl[11] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 3, 1, 0);
    tbl[12] = mk(0, 25'd0, 0, 0, 0, 1, NOPW, 0, 3, 0, 1);
    tbl[13] = mk(0, 25'd0, 0, 1, 1, 0, NOPW, 0, 0, 1, 0);
    tbl[14] = mk(0, 25'd0, 0, 0, 0, 0, 25'd1, 1, 1, 1, 0);
    tbl[15] = mk(0, 25'd0, 0, 0, 0, 0, 25'd2, 1, 2, 1, 0);
    tbl[16] = mk(0, 25'd0, 0, 0, 1, 0, 25'd2, 1, 2, 1, 0);
    tbl[17] = mk(0, 25'd0, 0, 0, 0, 0, 25'd3, 1, 3, 1, 0);
    tbl[18] = mk(0, 25'd0, 0, 0, 1, 0, 25'd3, 1, 3, 1, 0);
    tbl[19] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 3, 1, 0);
    tbl[20] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 3, 1, 0);
    tbl[21] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 3, 1, 0);
    tbl[22] = mk(0, 25'd0, 0, 0, 0, 1, NOPW, 0, 3, 0, 1);
    tbl[23] = mk(1, 25'd9, 0, 1, 1, 1, NOPW, 0, 3, 0, 0);
    tbl[24] = mk(1, 25'd10, 1, 0, 0, 1, NOPW, 0, 3, 0, 0);
    tbl[25] = mk(0, 25'd0, 0, 1, 0, 0, NOPW, 0, 0, 1, 0);
    tbl[26] = mk(0, 25'd0, 0, 0, 0, 0, 25'd9, 1, 1, 1, 0);
    tbl[27] = mk(0, 25'd0, 0, 0, 0, 0, 25'd10, 1, 2, 1, 0);
    tbl[28] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 2, 1, 0);
    tbl[29] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 2, 1, 0);
    tbl[30] = mk(0, 25'd0, 0, 0, 0, 0, NOPW, 0, 2, 1, 0);
    tbl[31] = mk(0, 25'd0, 0, 0, 0, 1, NOPW, 0, 2, 0, 1);

    do_reset();
    chk("rst.out",   32'(instr_out),   32'(NOPW));
    chk("rst.vld",   32'(instr_valid), 32'd0);
    chk("rst.pc",    32'(pc),          32'd0);
    chk("rst.ready", 32'(load_ready),  32'd1);
    chk("rst.busy",  32'(busy),        32'd0);
    chk("rst.done",  32'(done),        32'd0);
    chk("rst.ovf",   32'(overflow),    32'd0);

    for (int i = 0; i < 32; i++) begin
      load_valid = tbl[i].lv; load_instr = tbl[i].d; load_last = tbl[i].last;
      start = tbl[i].st; stall = tbl[i].sl;
      tick();
      $display("vec %0d: out=%h vld=%0d pc=%0d busy=%0d done=%0d", i, instr_out, instr_valid, pc, busy, done);
      chk($sformatf("vec%0d.ready", i), 32'(load_ready),  32'(tbl[i].ready));
      chk($sformatf("vec%0d.out", i),   32'(instr_out),   32'(tbl[i].out));
      chk($sformatf("vec%0d.vld", i),   32'(instr_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.pc", i),    32'(pc),          32'(tbl[i].pc));
      chk($sformatf("vec%0d.busy", i),  32'(busy),        32'(tbl[i].busy));
      chk($sformatf("vec%0d.done", i),  32'(done),        32'(tbl[i].done));
`ifdef IFU_PERF_CNT_EN
      if (i == 12 || i == 22) begin
        chk($sformatf("vec%0d.issued", i), 32'(issued_cnt), 32'd3);
        chk($sformatf("vec%0d.stalls", i), 32'(stall_cnt),  32'd2);
      end
`endif
    end
    idle_inputs();

    // Fill the memory, then try a 65th word.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = 25'h100000 + 25'(i);
      load_valid = 1'b1; load_instr = prog[i]; load_last = 1'b0;
      tick();
    end
    chk("full.ready", 32'(load_ready), 32'd0);
    chk("full.ovf0", 32'(overflow), 32'd0);
    load_instr = 25'h1ABCDE;
    tick();
    $display("overflow word: ready=%0d ovf=%0d", load_ready, overflow);
    chk("ovf.ready", 32'(load_ready), 32'd0);
    chk("ovf.flag",  32'(overflow),   32'd1);
    chk("ovf.busy",  32'(busy),       32'd0);
    load_last = 1'b1;
    tick();
    chk("ovf.loaded_ready", 32'(load_ready), 32'd1);
    chk("ovf.sticky", 32'(overflow), 32'd1);
    idle_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_run("full.k0", DEPTH, 0);
    for (int k = 1; k <= DEPTH + DRN; k++) begin
      tick();
      expect_run($sformatf("full.k%0d", k), DEPTH, k);
    end

    // Rerun from DONE, then reset asynchronously at pc=5.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid.pc5", 32'(pc), 32'd5);
    chk("mid.out", 32'(instr_out), 32'(prog[4]));
    rst_n = 1'b0;
    #1;
    $display("async reset: pc=%0d out=%h busy=%0d", pc, instr_out, busy);
    chk("arst.pc",    32'(pc),          32'd0);
    chk("arst.out",   32'(instr_out),   32'(NOPW));
    chk("arst.busy",  32'(busy),        32'd0);
    chk("arst.vld",   32'(instr_valid), 32'd0);
    chk("arst.ovf",   32'(overflow),    32'd0);
    chk("arst.ready", 32'(load_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst.start_ignored.busy", 32'(busy), 32'd0);
    chk("arst.start_ignored.vld",  32'(instr_valid), 32'd0);
    tick();
    chk("arst.still_idle", 32'(busy), 32'd0);

    // Randomized programs, including the single-word and full-memory extremes.
    do_reset();
    for (int it = 0; it < 6; it++) begin
      int n;
      n = (it == 0) ? 1 : (it == 1) ? DEPTH : $urandom_range(2, 40);
      load_prog(n);
      repeat ($urandom_range(0, 2)) tick();
      $display("random program %0d: n=%0d", it, n);
      run_prog(n);
      if ($urandom_range(0, 1) == 1) begin
        $display("random program %0d: rerun", it);
        run_prog(n);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
